// File: rtl/tcp_bus_arbiter.sv
// Purpose : round-robin arbiter sharing the single tcpBus command port of the AXI4 master
//           bridge between NUM_REQ requesters, one outstanding transaction at a time.
// Latency : grant registered on the cycle req_valid is seen; command strobe follows from
//           the same edge; bridge response reaches rsp_valid one cycle after rdata_valid.
// Backpressure: grant is held from command accept until the requester takes its response;
//           a response watchdog returns SLVERR to a stalled requester, then drains the late
//           bridge response before the next grant.
//
// Ports:
//   clk, reset                 clock, asynchronous active-low reset
//   req_valid/ready/write      per-requester command handshake and op type
//   req_addr/req_wdata         requester i at [32*i +: 32]
//   rsp_valid/ready            per-requester response handshake
//   rsp_rdata/rsp_resp         shared response data / AXI resp, qualified by rsp_valid
//   tcpBus_*                   command and response channels to/from the bridge
//   busy, grant_id             status: FSM not idle, current/last granted requester
module tcp_bus_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [NUM_REQ-1:0]     req_write,
  input  logic [32*NUM_REQ-1:0]  req_addr,
  input  logic [32*NUM_REQ-1:0]  req_wdata,
  output logic [NUM_REQ-1:0]     rsp_valid,
  input  logic [NUM_REQ-1:0]     rsp_ready,
  output logic [31:0]            rsp_rdata,
  output logic [1:0]             rsp_resp,
  output logic                   tcpBus_write,
  output logic [31:0]            tcpBus_addr,
  output logic                   tcpBus_wdata_valid,
  input  logic                   tcpBus_wdata_ready,
  output logic [31:0]            tcpBus_wdata_payload,
  input  logic                   tcpBus_rdata_valid,
  output logic                   tcpBus_rdata_ready,
  input  logic [31:0]            tcpBus_rdata_payload,
  input  logic [1:0]             tcpBus_rsp,
  output logic                   busy,
  output logic [2:0]             grant_id
);

  // Timer only needs to reach TIMEOUT-1; it saturates at all-ones.
  localparam int            TW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TMAX  = TW'(TIMEOUT - 1);
  localparam logic [3:0]    NR4   = 4'(NUM_REQ);
  localparam logic [2:0]    LAST  = 3'(NUM_REQ - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CMD     = 3'd1,
    RSP     = 3'd2,
    DELIVER = 3'd3,
    DRAIN   = 3'd4
  } state_t;

  state_t        state;
  logic [2:0]    rr_ptr;
  logic [TW-1:0] timer;
  logic          drain;

  // Requester vectors widened to 8 entries so a 3-bit index always fits exactly.
  logic [7:0]  valid8;
  logic [7:0]  write8;
  logic [7:0]  rsp_ready8;
  logic [31:0] addr_arr  [8];
  logic [31:0] wdata_arr [8];

  assign valid8     = 8'(req_valid);
  assign write8     = 8'(req_write);
  assign rsp_ready8 = 8'(rsp_ready);

  always_comb begin
    for (int i = 0; i < 8; i++) begin
      addr_arr[i]  = '0;
      wdata_arr[i] = '0;
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      addr_arr[i]  = req_addr[32*i +: 32];
      wdata_arr[i] = req_wdata[32*i +: 32];
    end
  end

  // Round-robin pick: first valid requester at or after rr_ptr, wrapping at NUM_REQ.
  logic       found;
  logic [2:0] gsel;
  logic [3:0] idx;

  always_comb begin
    found = 1'b0;
    gsel  = '0;
    idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = {1'b0, rr_ptr} + 4'(i);
      if (idx >= NR4) idx = idx - NR4;
      if (!found && valid8[idx[2:0]]) begin
        found = 1'b1;
        gsel  = idx[2:0];
      end
    end
  end

  logic [7:0] sel_onehot;
  logic [7:0] gnt_onehot;
  logic       timeout_hit;

  assign sel_onehot  = 8'b1 << gsel;
  assign gnt_onehot  = 8'b1 << grant_id;
  assign timeout_hit = (TIMEOUT != 0) && (timer == TMAX);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state                <= IDLE;
      req_ready            <= '0;
      rsp_valid            <= '0;
      rsp_rdata            <= '0;
      rsp_resp             <= '0;
      tcpBus_write         <= 1'b0;
      tcpBus_addr          <= '0;
      tcpBus_wdata_valid   <= 1'b0;
      tcpBus_wdata_payload <= '0;
      tcpBus_rdata_ready   <= 1'b0;
      busy                 <= 1'b0;
      grant_id             <= '0;
      rr_ptr               <= '0;
      timer                <= '0;
      drain                <= 1'b0;
    end else begin
      // req_ready is a single-cycle accept pulse.
      req_ready <= '0;
      case (state)
        IDLE: begin
          if (found) begin
            // The command is consumed here; the requester may move on after req_ready.
            tcpBus_write         <= write8[gsel];
            tcpBus_addr          <= addr_arr[gsel];
            tcpBus_wdata_payload <= wdata_arr[gsel];
            tcpBus_wdata_valid   <= 1'b1;
            req_ready            <= sel_onehot[NUM_REQ-1:0];
            grant_id             <= gsel;
            rr_ptr               <= (gsel == LAST) ? 3'd0 : gsel + 3'd1;
            busy                 <= 1'b1;
            state                <= CMD;
          end
        end

        CMD: begin
          if (tcpBus_wdata_ready) begin
            tcpBus_wdata_valid <= 1'b0;
            tcpBus_rdata_ready <= 1'b1;
            timer              <= '0;
            state              <= RSP;
          end
        end

        RSP: begin
          // A real response arriving on the timeout cycle takes priority.
          if (tcpBus_rdata_valid) begin
            rsp_rdata          <= tcpBus_rdata_payload;
            rsp_resp           <= tcpBus_rsp;
            rsp_valid          <= gnt_onehot[NUM_REQ-1:0];
            tcpBus_rdata_ready <= 1'b0;
            drain              <= 1'b0;
            state              <= DELIVER;
          end else if (timeout_hit) begin
            rsp_rdata          <= '0;
            rsp_resp           <= 2'b10;
            rsp_valid          <= gnt_onehot[NUM_REQ-1:0];
            tcpBus_rdata_ready <= 1'b0;
            drain              <= 1'b1;
            state              <= DELIVER;
          end else if (timer != '1) begin
            timer <= timer + 1'b1;
          end
        end

        DELIVER: begin
          if (rsp_ready8[grant_id]) begin
            rsp_valid <= '0;
            if (drain) begin
              // Bridge still owes a response; swallow it before re-arbitrating.
              tcpBus_rdata_ready <= 1'b1;
              state              <= DRAIN;
            end else begin
              busy  <= 1'b0;
              state <= IDLE;
            end
          end
        end

        DRAIN: begin
          if (tcpBus_rdata_valid) begin
            tcpBus_rdata_ready <= 1'b0;
            drain              <= 1'b0;
            busy               <= 1'b0;
            state              <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tcp_bus_arbiter.sv
// Purpose : directed self-checking bench for tcp_bus_arbiter (NUM_REQ=4, TIMEOUT=16).
// Latency : inputs driven 1 ns after the rising edge, outputs sampled at the same point.
// Backpressure: bridge and requester ready signals are driven by hand per scenario.
module tb_tcp_bus_arbiter;

  logic         clk = 1'b0;
  logic         reset;
  logic [3:0]   req_valid, req_ready, req_write, rsp_valid, rsp_ready;
  logic [127:0] req_addr, req_wdata;
  logic [31:0]  rsp_rdata;
  logic [1:0]   rsp_resp;
  logic         tcpBus_write;
  logic [31:0]  tcpBus_addr;
  logic         tcpBus_wdata_valid, tcpBus_wdata_ready;
  logic [31:0]  tcpBus_wdata_payload;
  logic         tcpBus_rdata_valid, tcpBus_rdata_ready;
  logic [31:0]  tcpBus_rdata_payload;
  logic [1:0]   tcpBus_rsp;
  logic         busy;
  logic [2:0]   grant_id;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  tcp_bus_arbiter #(.NUM_REQ(4), .TIMEOUT(16)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .tcpBus_write(tcpBus_write), .tcpBus_addr(tcpBus_addr),
    .tcpBus_wdata_valid(tcpBus_wdata_valid), .tcpBus_wdata_ready(tcpBus_wdata_ready),
    .tcpBus_wdata_payload(tcpBus_wdata_payload),
    .tcpBus_rdata_valid(tcpBus_rdata_valid), .tcpBus_rdata_ready(tcpBus_rdata_ready),
    .tcpBus_rdata_payload(tcpBus_rdata_payload), .tcpBus_rsp(tcpBus_rsp),
    .busy(busy), .grant_id(grant_id)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic w, input logic [31:0] a, input logic [31:0] d);
    req_write[i]        = w;
    req_addr[32*i +: 32]  = a;
    req_wdata[32*i +: 32] = d;
  endtask

  // Zero-delay bridge: accepts any command and answers any open response slot.
  task automatic bridge_auto(input logic [31:0] pl);
    tcpBus_wdata_ready   = tcpBus_wdata_valid;
    tcpBus_rdata_valid   = tcpBus_rdata_ready;
    tcpBus_rdata_payload = pl;
    tcpBus_rsp           = 2'b00;
  endtask

  task automatic run_to_idle(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 50; c++) begin
      bridge_auto(32'h0);
      tick;
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
    tcpBus_wdata_ready = 1'b0;
    tcpBus_rdata_valid = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    repeat (3) tick;
    checks++; if ({req_ready, rsp_valid} !== 8'h00) begin errors++; $display("FAIL reset_ready_valid: got %h want 00", {req_ready, rsp_valid}); end
    checks++; if ({tcpBus_wdata_valid, tcpBus_rdata_ready, busy, tcpBus_write} !== 4'b0000) begin errors++; $display("FAIL reset_ctrl: got %b want 0000", {tcpBus_wdata_valid, tcpBus_rdata_ready, busy, tcpBus_write}); end
    checks++; if ({tcpBus_addr, tcpBus_wdata_payload, rsp_rdata} !== 96'h0) begin errors++; $display("FAIL reset_data: got %h want 0", {tcpBus_addr, tcpBus_wdata_payload, rsp_rdata}); end
    checks++; if ({rsp_resp, grant_id} !== 5'h0) begin errors++; $display("FAIL reset_resp_gid: got %h want 0", {rsp_resp, grant_id}); end
    reset = 1'b1;
    tick;
  endtask

  task automatic test_single_write;
    set_req(0, 1'b1, 32'h100, 32'hDEADBEEF);
    rsp_ready = 4'h0;
    req_valid = 4'b0001;
    tick;
    req_valid = 4'b0000;
    checks++; if ({req_ready, grant_id, busy, tcpBus_wdata_valid} !== {4'b0001, 3'd0, 1'b1, 1'b1}) begin errors++; $display("FAIL wr_grant: got %h want %h", {req_ready, grant_id, busy, tcpBus_wdata_valid}, {4'b0001, 3'd0, 1'b1, 1'b1}); end
    checks++; if ({tcpBus_write, tcpBus_addr, tcpBus_wdata_payload} !== {1'b1, 32'h100, 32'hDEADBEEF}) begin errors++; $display("FAIL wr_fields: got %h want %h", {tcpBus_write, tcpBus_addr, tcpBus_wdata_payload}, {1'b1, 32'h100, 32'hDEADBEEF}); end
    repeat (2) tick;
    checks++; if ({req_ready, tcpBus_wdata_valid, tcpBus_addr} !== {4'b0000, 1'b1, 32'h100}) begin errors++; $display("FAIL wr_cmd_hold: got %h want %h", {req_ready, tcpBus_wdata_valid, tcpBus_addr}, {4'b0000, 1'b1, 32'h100}); end
    tcpBus_wdata_ready = 1'b1;
    tick;
    tcpBus_wdata_ready = 1'b0;
    checks++; if ({tcpBus_wdata_valid, tcpBus_rdata_ready} !== 2'b01) begin errors++; $display("FAIL wr_accept: got %b want 01", {tcpBus_wdata_valid, tcpBus_rdata_ready}); end
    repeat (2) tick;
    tcpBus_rdata_valid   = 1'b1;
    tcpBus_rdata_payload = 32'h0;
    tcpBus_rsp           = 2'b00;
    tick;
    tcpBus_rdata_valid = 1'b0;
    checks++; if ({rsp_valid, rsp_resp, tcpBus_rdata_ready} !== {4'b0001, 2'b00, 1'b0}) begin errors++; $display("FAIL wr_rsp: got %h want %h", {rsp_valid, rsp_resp, tcpBus_rdata_ready}, {4'b0001, 2'b00, 1'b0}); end
    rsp_ready = 4'b0001;
    tick;
    rsp_ready = 4'b0000;
    checks++; if ({rsp_valid, busy} !== 5'b0) begin errors++; $display("FAIL wr_done: got %b want 00000", {rsp_valid, busy}); end
  endtask

  task automatic test_round_robin;
    int  n;
    bit  outstanding;
    bit  ok;
    reset = 1'b0;
    tick;
    reset = 1'b1;
    tick;
    for (int i = 0; i < 4; i++) set_req(i, 1'b1, 32'(32'h1000 + 16 * i), 32'(32'hA0 + i));
    rsp_ready   = 4'hF;
    req_valid   = 4'hF;
    n           = 0;
    outstanding = 1'b0;
    for (int c = 0; c < 200 && n < 8; c++) begin
      bridge_auto(32'h0);
      tick;
      if (rsp_valid != 4'h0) outstanding = 1'b0;
      if (req_ready != 4'h0) begin
        checks++; if ({req_ready, grant_id} !== {4'(1 << (n % 4)), 3'(n % 4)}) begin errors++; $display("FAIL rr_order[%0d]: got %h want %h", n, {req_ready, grant_id}, {4'(1 << (n % 4)), 3'(n % 4)}); end
        checks++; if (tcpBus_addr !== 32'(32'h1000 + 16 * (n % 4))) begin errors++; $display("FAIL rr_addr[%0d]: got %h want %h", n, tcpBus_addr, 32'(32'h1000 + 16 * (n % 4))); end
        checks++; if (outstanding !== 1'b0) begin errors++; $display("FAIL rr_overlap[%0d]: got outstanding %b want 0", n, outstanding); end
        outstanding = 1'b1;
        n++;
        if (n == 8) req_valid = 4'h0;
      end
    end
    checks++; if (n !== 8) begin errors++; $display("FAIL rr_count: got %0d want 8", n); end
    run_to_idle(ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL rr_idle: got %b want 1", ok); end
  endtask

  task automatic test_read_routing;
    rsp_ready = 4'h0;
    set_req(2, 1'b0, 32'h200, 32'h0);
    req_valid = 4'b0100;
    tick;
    req_valid = 4'b0000;
    checks++; if ({req_ready, grant_id, tcpBus_write, tcpBus_addr} !== {4'b0100, 3'd2, 1'b0, 32'h200}) begin errors++; $display("FAIL rd_grant: got %h want %h", {req_ready, grant_id, tcpBus_write, tcpBus_addr}, {4'b0100, 3'd2, 1'b0, 32'h200}); end
    tcpBus_wdata_ready = 1'b1;
    tick;
    tcpBus_wdata_ready   = 1'b0;
    tcpBus_rdata_valid   = 1'b1;
    tcpBus_rdata_payload = 32'h12345678;
    tcpBus_rsp           = 2'b00;
    tick;
    tcpBus_rdata_valid = 1'b0;
    checks++; if ({rsp_valid, rsp_rdata, rsp_resp} !== {4'b0100, 32'h12345678, 2'b00}) begin errors++; $display("FAIL rd_route: got %h want %h", {rsp_valid, rsp_rdata, rsp_resp}, {4'b0100, 32'h12345678, 2'b00}); end
    rsp_ready = 4'b0100;
    tick;
    rsp_ready = 4'b0000;
    checks++; if ({rsp_valid, busy} !== 5'b0) begin errors++; $display("FAIL rd_done: got %b want 00000", {rsp_valid, busy}); end
  endtask

  task automatic test_rsp_backpressure;
    bit ok;
    rsp_ready = 4'h0;
    set_req(1, 1'b1, 32'h300, 32'hA5A5A5A5);
    req_valid = 4'b0010;
    tick;
    req_valid = 4'b0000;
    checks++; if (grant_id !== 3'd1) begin errors++; $display("FAIL bp_grant: got %0d want 1", grant_id); end
    tcpBus_wdata_ready = 1'b1;
    tick;
    tcpBus_wdata_ready   = 1'b0;
    tcpBus_rdata_valid   = 1'b1;
    tcpBus_rdata_payload = 32'hCAFEF00D;
    tcpBus_rsp           = 2'b01;
    tick;
    tcpBus_rdata_valid = 1'b0;
    set_req(0, 1'b1, 32'h111, 32'h1);
    set_req(3, 1'b0, 32'h333, 32'h0);
    req_valid = 4'b1001;
    for (int c = 0; c < 10; c++) begin
      checks++; if ({rsp_valid, rsp_resp, rsp_rdata, req_ready, busy} !== {4'b0010, 2'b01, 32'hCAFEF00D, 4'b0000, 1'b1}) begin errors++; $display("FAIL bp_hold[%0d]: got %h want %h", c, {rsp_valid, rsp_resp, rsp_rdata, req_ready, busy}, {4'b0010, 2'b01, 32'hCAFEF00D, 4'b0000, 1'b1}); end
      tick;
    end
    rsp_ready = 4'b0010;
    tick;
    rsp_ready = 4'b0000;
    checks++; if ({rsp_valid, req_ready} !== 8'h00) begin errors++; $display("FAIL bp_release: got %h want 00", {rsp_valid, req_ready}); end
    tick;
    req_valid = 4'b0000;
    checks++; if ({req_ready, grant_id, tcpBus_addr} !== {4'b1000, 3'd3, 32'h333}) begin errors++; $display("FAIL bp_next_grant: got %h want %h", {req_ready, grant_id, tcpBus_addr}, {4'b1000, 3'd3, 32'h333}); end
    rsp_ready = 4'hF;
    run_to_idle(ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL bp_idle: got %b want 1", ok); end
  endtask

  task automatic test_timeout_drain;
    int first;
    bit bad;
    bit ok;
    rsp_ready = 4'h0;
    set_req(0, 1'b0, 32'h400, 32'h0);
    req_valid = 4'b0001;
    tick;
    req_valid = 4'b0000;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL to_grant: got %b want 0001", req_ready); end
    tcpBus_wdata_ready = 1'b1;
    tick;
    tcpBus_wdata_ready = 1'b0;
    first = -1;
    for (int k = 1; k <= 17; k++) begin
      tick;
      if (rsp_valid != 4'h0 && first < 0) first = k;
    end
    checks++; if (first !== 16) begin errors++; $display("FAIL to_cycle: got %0d want 16", first); end
    checks++; if ({rsp_valid, rsp_resp, rsp_rdata} !== {4'b0001, 2'b10, 32'h0}) begin errors++; $display("FAIL to_slverr: got %h want %h", {rsp_valid, rsp_resp, rsp_rdata}, {4'b0001, 2'b10, 32'h0}); end
    rsp_ready = 4'b0001;
    tick;
    rsp_ready = 4'b0000;
    checks++; if ({rsp_valid, busy, tcpBus_rdata_ready} !== {4'b0000, 1'b1, 1'b1}) begin errors++; $display("FAIL to_drain_enter: got %b want 000011", {rsp_valid, busy, tcpBus_rdata_ready}); end
    bad = 1'b0;
    for (int k = 19; k <= 39; k++) begin
      tick;
      if (rsp_valid != 4'h0 || tcpBus_rdata_ready != 1'b1 || busy != 1'b1) bad = 1'b1;
    end
    checks++; if (bad !== 1'b0) begin errors++; $display("FAIL to_drain_wait: got %b want 0", bad); end
    tcpBus_rdata_valid   = 1'b1;
    tcpBus_rdata_payload = 32'hBAD0BAD0;
    tcpBus_rsp           = 2'b00;
    tick;
    tcpBus_rdata_valid = 1'b0;
    checks++; if ({busy, tcpBus_rdata_ready, rsp_valid, rsp_rdata} !== {1'b0, 1'b0, 4'b0000, 32'h0}) begin errors++; $display("FAIL to_drained: got %h want 0", {busy, tcpBus_rdata_ready, rsp_valid, rsp_rdata}); end
    tick;
    checks++; if (rsp_valid !== 4'b0000) begin errors++; $display("FAIL to_no_late_deliver: got %b want 0000", rsp_valid); end
    set_req(3, 1'b1, 32'h4444, 32'h4);
    req_valid = 4'b1000;
    tick;
    req_valid = 4'b0000;
    checks++; if ({req_ready, grant_id} !== {4'b1000, 3'd3}) begin errors++; $display("FAIL to_next_grant: got %h want %h", {req_ready, grant_id}, {4'b1000, 3'd3}); end
    rsp_ready = 4'hF;
    run_to_idle(ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL to_idle: got %b want 1", ok); end
  endtask

  task automatic test_timeout_race;
    rsp_ready = 4'h0;
    set_req(0, 1'b0, 32'h500, 32'h0);
    req_valid = 4'b0001;
    tick;
    req_valid          = 4'b0000;
    tcpBus_wdata_ready = 1'b1;
    tick;
    tcpBus_wdata_ready = 1'b0;
    for (int k = 1; k <= 15; k++) tick;
    tcpBus_rdata_valid   = 1'b1;
    tcpBus_rdata_payload = 32'h55AA33CC;
    tcpBus_rsp           = 2'b00;
    tick;
    tcpBus_rdata_valid = 1'b0;
    checks++; if ({rsp_valid, rsp_rdata, rsp_resp} !== {4'b0001, 32'h55AA33CC, 2'b00}) begin errors++; $display("FAIL race_rsp_wins: got %h want %h", {rsp_valid, rsp_rdata, rsp_resp}, {4'b0001, 32'h55AA33CC, 2'b00}); end
    rsp_ready = 4'b0001;
    tick;
    rsp_ready = 4'b0000;
    checks++; if ({busy, tcpBus_rdata_ready} !== 2'b00) begin errors++; $display("FAIL race_no_drain: got %b want 00", {busy, tcpBus_rdata_ready}); end
  endtask

  task automatic test_reset_midflight;
    bit ok;
    rsp_ready = 4'h0;
    set_req(2, 1'b1, 32'h600, 32'h66666666);
    req_valid = 4'b0100;
    tick;
    req_valid = 4'b0000;
    checks++; if (grant_id !== 3'd2) begin errors++; $display("FAIL rst_pre_grant: got %0d want 2", grant_id); end
    tcpBus_wdata_ready = 1'b1;
    tick;
    tcpBus_wdata_ready = 1'b0;
    tick;
    reset = 1'b0;
    #1;
    checks++; if ({req_ready, rsp_valid, tcpBus_wdata_valid, tcpBus_rdata_ready, busy, tcpBus_write} !== 12'h0) begin errors++; $display("FAIL rst_mid_ctrl: got %h want 0", {req_ready, rsp_valid, tcpBus_wdata_valid, tcpBus_rdata_ready, busy, tcpBus_write}); end
    checks++; if ({tcpBus_addr, tcpBus_wdata_payload, rsp_rdata, rsp_resp, grant_id} !== 101'h0) begin errors++; $display("FAIL rst_mid_data: got %h want 0", {tcpBus_addr, tcpBus_wdata_payload, rsp_rdata, rsp_resp, grant_id}); end
    tick;
    tick;
    reset = 1'b1;
    tick;
    set_req(1, 1'b0, 32'h700, 32'h0);
    req_valid = 4'b0110;
    tick;
    req_valid = 4'b0000;
    checks++; if ({req_ready, grant_id, tcpBus_addr} !== {4'b0010, 3'd1, 32'h700}) begin errors++; $display("FAIL rst_after_grant: got %h want %h", {req_ready, grant_id, tcpBus_addr}, {4'b0010, 3'd1, 32'h700}); end
    rsp_ready = 4'hF;
    run_to_idle(ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL rst_after_idle: got %b want 1", ok); end
  endtask

  initial begin
    reset                = 1'b0;
    req_valid            = '0;
    req_write            = '0;
    req_addr             = '0;
    req_wdata            = '0;
    rsp_ready            = '0;
    tcpBus_wdata_ready   = 1'b0;
    tcpBus_rdata_valid   = 1'b0;
    tcpBus_rdata_payload = '0;
    tcpBus_rsp           = '0;
    #1;
    test_reset;
    test_single_write;
    test_round_robin;
    test_read_routing;
    test_rsp_backpressure;
    test_timeout_drain;
    test_timeout_race;
    test_reset_midflight;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
